oled_spi_rx: RTL and testbench
==============================

# oled_spi_rx

Synthesizable SPI receiver for the SSD1331 PMOD link: the display-side end of the OLED SPI master. It samples the four pin-level signals (CS, MOSI, SCK, D/C), deserializes MSB-first words and tags each with its D/C level. Received words are presented on a valid/ready stream with sticky error flags and a word counter. It is used in loopback and bring-up to check the OLED command/data stream on-chip without a display attached.

## Interface
- N, 8: bits per received word.
- SYNC_STAGES, 2: flip-flop stages on each pin input (minimum 2).
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2; used only when the FIFO is compiled in.
- i_CLK  in  1  system clock (100 MHz); must be ≥4× SCK frequency.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_CS  in  1  chip select pin, active-low, asynchronous to i_CLK.
- i_MOSI  in  1  serial data pin.
- i_SCK  in  1  serial clock pin; idles high (SPI mode 3), data sampled on rising edge.
- i_DC  in  1  data/command pin: 0 = command, 1 = data.
- i_READY  in  1  consumer accepts the head word when high with o_VALID.
- i_CLR  in  1  synchronous pulse; clears o_OVERFLOW, o_FRAME_ERR and o_WORD_CNT.
- o_VALID  out  1  head word available.
- o_DATA  out  N  head word, first bit received in the MSB.
- o_DC  out  1  D/C level captured with the head word.
- o_BUSY  out  1  synchronized CS is low (transfer in progress).
- o_OVERFLOW  out  1  sticky; a completed word was dropped.
- o_FRAME_ERR  out  1  sticky; CS rose with 1..N-1 bits shifted.
- o_WORD_CNT  out  16  count of words accepted into storage; wraps 0xFFFF→0x0000.

## Operation
- Each pin input passes through SYNC_STAGES flops. Synchronized SCK is registered once more for edge detection. A rising edge is `sck_s & ~sck_q`.
- FSM states:
  - IDLE: synchronized CS high. Bit counter = 0, shift register cleared. On CS low → SHIFT.
  - SHIFT: on each SCK rising edge, shift register ← {sr[N-2:0], mosi_s} and bit counter +1.
    - On the Nth edge, the word is formed from the shift register plus that edge's MOSI bit, with D/C = dc_s sampled on the same cycle. The word is pushed, the counter goes to 0, and the FSM stays in SHIFT. Multi-word transfers under one CS are supported.
    - On CS high: counter 0 → IDLE. Counter ≠0 → partial word discarded, o_FRAME_ERR set, → IDLE.
- SCK edges while in IDLE are ignored.
- Push: if storage has space, or a pop occurs in the same cycle, the word is stored and o_WORD_CNT increments. Otherwise the word is dropped and o_OVERFLOW is set.
- Pop: o_VALID & i_READY. o_DATA/o_DC advance to the next entry on the following cycle.
- i_CLR in the same cycle as a new error event: the error wins (flag ends set). i_CLR with a push: counter ends at 1.
- Reset: FSM IDLE, storage empty, o_VALID=0, o_DATA=0, o_DC=0, o_BUSY=0, o_OVERFLOW=0, o_FRAME_ERR=0, o_WORD_CNT=0. Synchronizer flops reset to 1 (CS/SCK idle-high); MOSI/DC synchronizers reset to 0.
- Reset asserted mid-transfer discards the partial word. After release, the FSM waits in IDLE until CS is seen high then low again. A transfer already in progress is not joined.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 i_CLK cycles from the SCK rising edge at the pin to the internal edge pulse.
- Push latency: the word is written on the edge-pulse cycle. o_VALID rises the next cycle, SYNC_STAGES+2 cycles (4 by default) after the Nth SCK rising edge.
- Empty storage with i_READY held high: each word is visible for exactly one cycle.
- o_BUSY follows the pin CS inverted with SYNC_STAGES cycles of delay.
- MOSI and DC must be stable ≥1 i_CLK period before and after the SCK rising edge at the pin. The shared synchronizer depth aligns them.
- All outputs are registered. There is no combinational path from i_READY to any output.

## Configuration
- OLED_SPI_RX_FIFO_EN defined: storage is a FIFO of FIFO_DEPTH entries, each {dc, data}. The full/empty rules above apply, and simultaneous push and pop when full is accepted without overflow.
- Not defined: storage is a single holding register (depth 1). A push when the register is valid and not popped the same cycle sets o_OVERFLOW and keeps the old word. FIFO_DEPTH is ignored.

## Test plan
- Single command: CS low, send 0xAF with DC=0 at 5 MHz SCK, CS high → one word 0xAF, o_DC=0, o_WORD_CNT=1, no error flags.
- Burst under one CS: 0x15 (DC=0), then 0x00, 0x5F (DC=1), i_READY=1 → words 0x15/0, 0x00/1, 0x5F/1 in order; o_VALID rises 4 cycles after each 8th SCK rise.
- Frame error: CS rises after 5 bits → no word, o_FRAME_ERR=1. The next full byte 0xA5 is received correctly. i_CLR clears the flag and the count.
- Overflow: i_READY=0, send FIFO_DEPTH+1 bytes 0x01..0x05 → 0x01..0x04 retained, o_OVERFLOW=1, count=4. Without the macro: 0x01 retained, count=1.
- Full with simultaneous pop: FIFO full, i_READY pulsed on the push cycle → no overflow, last word retained.
- Reset mid-byte: assert i_RST_N low after 3 bits → all outputs at reset values. Remaining bits of the same CS frame are ignored. The next CS frame is received normally.

Source files
------------

// File: rtl/oled_spi_rx.sv
// Display-side SPI receiver for the SSD1331 PMOD link: deserializes MSB-first words tagged with D/C.
// Storage is a FIFO_DEPTH-entry FIFO when OLED_SPI_RX_FIFO_EN is defined, otherwise a single holding register.
module oled_spi_rx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         i_CLK,
  input  logic         i_RST_N,
  input  logic         i_CS,
  input  logic         i_MOSI,
  input  logic         i_SCK,
  input  logic         i_DC,
  input  logic         i_READY,
  input  logic         i_CLR,
  output logic         o_VALID,
  output logic [N-1:0] o_DATA,
  output logic         o_DC,
  output logic         o_BUSY,
  output logic         o_OVERFLOW,
  output logic         o_FRAME_ERR,
  output logic [15:0]  o_WORD_CNT
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, dc_sync_q, fill_q;
  logic                   sck_q, busy_q, armed_q;
  logic                   cs_s, sck_s, mosi_s, dc_s, sck_rise;

  state_t                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [N-1:0]           sr_q;

  logic                   word_push, frame_evt, push_ok, ovf_evt, pop;
  logic [N-1:0]           word_data;
  logic                   word_dc;

  logic                   valid_q, dc_q, ovf_q, ferr_q;
  logic [N-1:0]           data_q;
  logic [15:0]            word_cnt_q;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // fill_q marks when the synchronizers hold real pin values, so the idle-high
  // reset value of CS cannot arm the receiver in the middle of a live frame.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      fill_q      <= '0;
      sck_q       <= 1'b1;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_CS};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], i_DC};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_q       <= sck_s;
      busy_q      <= ~cs_sync_q[SYNC_STAGES-2];
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    end
  end

  always_comb begin
    sck_rise  = sck_s & ~sck_q;
    word_push = (state_q == SHIFT) & ~cs_s & sck_rise & (bit_cnt_q == CNT_W'(N-1));
    word_data = {sr_q[N-2:0], mosi_s};
    word_dc   = dc_s;
    frame_evt = (state_q == SHIFT) & cs_s & (bit_cnt_q != '0);
  end

  // state | meaning
  // IDLE  | CS high (or not yet seen high since reset); counter and shift register cleared
  // SHIFT | CS low; shifting one bit per SCK rising edge, pushing every Nth bit
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          sr_q      <= '0;
          if (armed_q && !cs_s) state_q <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
          end else if (sck_rise) begin
            sr_q      <= word_data;
            bit_cnt_q <= word_push ? '0 : bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop = valid_q & i_READY;

`ifdef OLED_SPI_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  logic [N:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [N:0]    head_d;

  always_comb begin
    push_ok = word_push & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop);
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop) cnt_d = cnt_q + (AW+1)'(1);
    if (!push_ok && pop) cnt_d = cnt_q - (AW+1)'(1);
    // The head slot may be the one being written this very cycle.
    head_d  = (push_ok && (rd_d == wr_q)) ? {word_dc, word_data} : mem_q[rd_d];
  end

  always_ff @(posedge i_CLK) begin
    if (push_ok) mem_q[wr_q] <= {word_dc, word_data};
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      if (cnt_d != '0) {dc_q, data_q} <= head_d;
    end
  end
`else
  assign push_ok = word_push & (~valid_q | pop);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      valid_q <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= '0;
    end else if (push_ok) begin
      valid_q <= 1'b1;
      dc_q    <= word_dc;
      data_q  <= word_data;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign ovf_evt = word_push & ~push_ok;

  // A same-cycle error event beats i_CLR; a same-cycle push leaves the count at 1.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      ovf_q  <= ovf_evt | (ovf_q & ~i_CLR);
      ferr_q <= frame_evt | (ferr_q & ~i_CLR);
      if (push_ok)    word_cnt_q <= i_CLR ? 16'd1 : word_cnt_q + 16'd1;
      else if (i_CLR) word_cnt_q <= '0;
    end
  end

  assign o_VALID     = valid_q;
  assign o_DATA      = data_q;
  assign o_DC        = dc_q;
  assign o_BUSY      = busy_q;
  assign o_OVERFLOW  = ovf_q;
  assign o_FRAME_ERR = ferr_q;
  assign o_WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: stimulus queues expected words, a monitor pops them on each handshake.
module tb_oled_spi_rx;
  localparam int N  = 8;
  localparam int SS = 2;
`ifdef OLED_SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, mosi = 1'b0, sck = 1'b1, dc = 1'b0;
  logic ready = 1'b0, clr = 1'b0;
  logic         o_valid, o_dc, o_busy, o_ovf, o_ferr;
  logic [N-1:0] o_data;
  logic [15:0]  o_cnt;

  oled_spi_rx #(.N(N), .SYNC_STAGES(SS), .FIFO_DEPTH(4)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck), .i_DC(dc),
    .i_READY(ready), .i_CLR(clr),
    .o_VALID(o_valid), .o_DATA(o_data), .o_DC(o_dc), .o_BUSY(o_busy),
    .o_OVERFLOW(o_ovf), .o_FRAME_ERR(o_ferr), .o_WORD_CNT(o_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       dc;
  } exp_t;
  exp_t sb[$];

  int   n_vec = 0, n_err = 0;
  int   last_rise = 0;
  bit   lat_en = 1'b0;
  logic valid_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SPI mode 3: data changes with SCK low, sampled on the rising edge; 20 clk periods per SCK bit (5 MHz).
  task automatic send(input logic [7:0] w, input int nb, input logic d, input bit expect_word,
                      input bit pulse_rdy);
    if (expect_word) sb.push_back('{w, d});
    for (int i = 0; i < nb; i++) begin
      sck  = 1'b0;
      mosi = w[7-i];
      dc   = d;
      tick(10);
      sck       = 1'b1;
      last_rise = cyc;
      if (pulse_rdy && i == nb - 1) begin
        // Edge pulse sits two cycles after the pin rise; hold READY across exactly that cycle.
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(7);
      end else begin
        tick(10);
      end
    end
  endtask

  task automatic frame_start();
    cs = 1'b0;
    tick(10);
  endtask

  task automatic frame_end();
    tick(5);
    cs = 1'b1;
    tick(20);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
  endtask

  initial begin
    fork
      begin : mon
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            // Rise seen after SS+1 posedges from the pin edge, i.e. in the 4th cycle counting the edge's own.
            if (lat_en && o_valid && !valid_prev)
              chk("valid_latency", 32'(cyc - last_rise), 32'(SS + 1));
            if (o_valid && ready) begin
              if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h/%0b, none expected", o_data, o_dc);
              end else begin
                e = sb.pop_front();
                chk("word_data", 32'(o_data), 32'(e.d));
                chk("word_dc", 32'(o_dc), 32'(e.dc));
              end
            end
          end
          valid_prev = o_valid;
        end
      end
      begin : stim
        tick(3);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_flags", 32'({o_ovf, o_ferr}), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        rst_n = 1'b1;
        tick(5);

        // single command
        ready = 1'b1;
        frame_start();
        chk("busy_in_frame", 32'(o_busy), 1);
        send(8'hAF, 8, 1'b0, 1'b1, 1'b0);
        frame_end();
        chk("t1_cnt", 32'(o_cnt), 1);
        chk("t1_flags", 32'({o_ovf, o_ferr}), 0);
        chk("t1_drained", 32'(sb.size()), 0);
        chk("busy_idle", 32'(o_busy), 0);

        // burst under one CS with latency check
        lat_en = 1'b1;
        frame_start();
        send(8'h15, 8, 1'b0, 1'b1, 1'b0);
        send(8'h00, 8, 1'b1, 1'b1, 1'b0);
        send(8'h5F, 8, 1'b1, 1'b1, 1'b0);
        frame_end();
        lat_en = 1'b0;
        chk("t2_cnt", 32'(o_cnt), 4);
        chk("t2_drained", 32'(sb.size()), 0);

        // frame error, recovery, clear
        frame_start();
        send(8'hB8, 5, 1'b0, 1'b0, 1'b0);
        frame_end();
        chk("t3_ferr", 32'(o_ferr), 1);
        chk("t3_cnt_nochange", 32'(o_cnt), 4);
        frame_start();
        send(8'hA5, 8, 1'b1, 1'b1, 1'b0);
        frame_end();
        chk("t3_cnt", 32'(o_cnt), 5);
        chk("t3_ferr_sticky", 32'(o_ferr), 1);
        clr_pulse();
        chk("t3_ferr_clr", 32'(o_ferr), 0);
        chk("t3_cnt_clr", 32'(o_cnt), 0);

        // overflow with consumer stalled
        ready = 1'b0;
        frame_start();
        for (int k = 1; k <= 5; k++) send(8'(k), 8, 1'b0, k <= DEPTH, 1'b0);
        frame_end();
        chk("t4_ovf", 32'(o_ovf), 1);
        chk("t4_cnt", 32'(o_cnt), 32'(DEPTH));
        chk("t4_valid", 32'(o_valid), 1);
        ready = 1'b1;
        tick(DEPTH + 3);
        chk("t4_drained", 32'(sb.size()), 0);
        chk("t4_empty", 32'(o_valid), 0);
        clr_pulse();
        chk("t4_ovf_clr", 32'(o_ovf), 0);

        // full storage with a pop on the push cycle
        ready = 1'b0;
        frame_start();
        for (int k = 0; k < DEPTH; k++) send(8'(8'h10 + k), 8, 1'b0, 1'b1, 1'b0);
        send(8'h20, 8, 1'b1, 1'b1, 1'b1);
        frame_end();
        chk("t5_no_ovf", 32'(o_ovf), 0);
        chk("t5_cnt", 32'(o_cnt), 32'(DEPTH + 1));
        ready = 1'b1;
        tick(DEPTH + 3);
        chk("t5_drained", 32'(sb.size()), 0);

        // reset in the middle of a byte
        frame_start();
        send(8'hE0, 3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1);
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_data", 32'({o_data, o_dc}), 0);
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_flags", 32'({o_ovf, o_ferr}), 0);
        chk("t6_cnt", 32'(o_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        send(8'hC3, 8, 1'b1, 1'b0, 1'b0);
        frame_end();
        chk("t6_ignored_cnt", 32'(o_cnt), 0);
        chk("t6_ignored_ferr", 32'(o_ferr), 0);
        frame_start();
        send(8'h3C, 8, 1'b1, 1'b1, 1'b0);
        frame_end();
        chk("t6_next_cnt", 32'(o_cnt), 1);
        chk("final_drained", 32'(sb.size()), 0);
      end
      begin : wd
        #2000000;
        n_vec++;
        n_err++;
        $display("FAIL timeout: stimulus did not complete within time limit");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
